// File: rtl/alu_exec_if.sv
// alu_exec_if: upstream op and downstream result handshake bundle of the EX stage
interface alu_exec_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [TAGW-1:0]  rd_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [TAGW-1:0]  rd_out;
  modport master (
    output in_valid, alu_ctrl, src_a, src_b, rd_in, out_ready,
    input  in_ready, out_valid, result, zero, illegal, rd_out
  );
  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, rd_in, out_ready,
    output in_ready, out_valid, result, zero, illegal, rd_out
  );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: RV32I EX-stage ALU with registered result and 2-entry skid buffer
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input logic      clk,
  input logic      reset,
  input logic      flush,
  alu_exec_if.slave bus
);
  localparam int EW = 1 + TAGW + WIDTH;
  logic             m_v, s_v, m_zero, acc, pop, load_main, n_ill;
  logic [WIDTH-1:0] n_res;
  logic [EW-1:0]    n_e, nm_e, m_e, s_e;
  assign acc         = bus.in_valid & ~s_v;
  assign pop         = m_v & bus.out_ready;
  assign load_main   = ~m_v | pop;
  assign bus.in_ready  = ~s_v;
  assign bus.out_valid = m_v;
  assign bus.result    = m_e[WIDTH-1:0];
  assign bus.rd_out    = m_e[WIDTH +: TAGW];
  assign bus.illegal   = m_e[EW-1];
  assign bus.zero      = m_zero;
  // operate on the incoming op; the skid entry has priority for the main slot to keep FIFO order
  always_comb begin
    n_ill = bus.alu_ctrl == 3'b100 || bus.alu_ctrl == 3'b110 || bus.alu_ctrl == 3'b111;
    n_res = bus.alu_ctrl == 3'b000 ? bus.src_a + bus.src_b :
            bus.alu_ctrl == 3'b001 ? bus.src_a - bus.src_b :
            bus.alu_ctrl == 3'b010 ? bus.src_a & bus.src_b :
            bus.alu_ctrl == 3'b011 ? bus.src_a | bus.src_b :
            bus.alu_ctrl == 3'b101 ? {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)} :
            '0;
    n_e  = {n_ill, bus.rd_in, n_res};
    nm_e = s_v ? s_e : n_e;
  end
  // main/skid entry state; outputs hold their last values once the stage drains
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_v    <= 1'b0;
      s_v    <= 1'b0;
      m_e    <= '0;
      s_e    <= '0;
      m_zero <= 1'b0;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (load_main) begin
      m_v <= s_v | acc;
      s_v <= 1'b0;
      if (s_v | acc) begin
        m_e    <= nm_e;
        m_zero <= nm_e[WIDTH-1:0] == '0;
      end
    end else if (acc) begin
      s_v <= 1'b1;
      s_e <= n_e;
    end
  end
endmodule
